// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (optional MULDIV_EARLY_OUT_EN)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic                b_zero_q, b_zero_d;
    logic [XLEN-1:0]     b_mag_q, b_mag_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                sa_in, sb_in;
    logic [XLEN-1:0]     a_mag_in, b_mag_in;
    logic [XLEN:0]       mul_upper;
    logic [XLEN:0]       r_sh, diff;
    logic [2*XLEN-1:0]   mul_next, div_next, acc_next;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s, rem_s, final_val;

    // Operand signs and magnitudes as seen at the accepting edge.
    always_comb begin
        sa_in    = 1'b0;
        sb_in    = 1'b0;
        case (funct3)
            3'b001: begin sa_in = a[XLEN-1]; sb_in = b[XLEN-1]; end
            3'b010: sa_in = a[XLEN-1];
            3'b100, 3'b110: begin sa_in = a[XLEN-1]; sb_in = b[XLEN-1]; end
            default: ;
        endcase
        a_mag_in = sa_in ? (~a + 1'b1) : a;
        b_mag_in = sb_in ? (~b + 1'b1) : b;
    end

    // One iteration of shift-add multiply or restoring divide, sharing acc_q.
    always_comb begin
        mul_upper = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, b_mag_q} : '0);
        mul_next  = {mul_upper, acc_q[XLEN-1:1]};
        r_sh      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff      = r_sh - {1'b0, b_mag_q};
        if (diff[XLEN])
            div_next = {r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        acc_next  = op_q[2] ? div_next : mul_next;
    end

    // Sign correction applied to the value produced by the last iteration.
    always_comb begin
        prod_s = (sign_a_q ^ sign_b_q) ? (~acc_next + 1'b1) : acc_next;
        if (b_zero_q)
            quo_s = '1;
        else if (sign_a_q ^ sign_b_q)
            quo_s = ~acc_next[XLEN-1:0] + 1'b1;
        else
            quo_s = acc_next[XLEN-1:0];
        rem_s = sign_a_q ? (~acc_next[2*XLEN-1:XLEN] + 1'b1)
                         : acc_next[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 final_val = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = quo_s;
            default:                final_val = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d     = funct3;
                    sign_a_d = sa_in;
                    sign_b_d = sb_in;
                    b_zero_d = (b == '0);
                    b_mag_d  = b_mag_in;
                    acc_d    = {{XLEN{1'b0}}, a_mag_in};
                    cnt_d    = '0;
                    state_d  = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    // Trivial results skip the iteration entirely.
                    if (!funct3[2] && (a == '0 || b == '0)) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else if (funct3[2] && b == '0) begin
                        result_d = funct3[1] ? a : '1;
                        state_d  = S_DONE;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = acc_next;
                if (cnt_q == CNT_LAST) begin
                    result_d = final_val;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort leaves result untouched and cancels any same-cycle launch.
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .funct3(funct3), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] p;
        logic signed [31:0] sx, sy;
        sx = x;
        sy = y;
        case (f)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
            3'd2: begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                return sx / sy;
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return sx % sy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (!f[2] && (x == 0 || y == 0)) return 1;
        if (f[2] && y == 0) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Called right after the accepting edge; lat counts the start cycle as 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            if (busy && done) overlap++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic launch(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        funct3 = f;
        a      = av;
        b      = bv;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        funct3 = 3'($urandom);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] res, output int lat);
        launch(f, av, bv);
        wait_done(lat);
        res = result;
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk(name, seen, 0);
    endtask

    vec_t tbl[18];

    initial begin
        logic [31:0] res, ea, eb;
        logic [2:0]  ef;
        int          lat;

        tbl[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        tbl[1]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
        tbl[2]  = '{3'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        tbl[3]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        tbl[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
        tbl[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
        tbl[6]  = '{3'd5, 32'h00000007, 32'h00000002, 32'h00000003};
        tbl[7]  = '{3'd7, 32'h00000007, 32'h00000002, 32'h00000001};
        tbl[8]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        tbl[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        tbl[10] = '{3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF};
        tbl[11] = '{3'd6, 32'h00000005, 32'h00000000, 32'h00000005};
        tbl[12] = '{3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF};
        tbl[13] = '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005};
        tbl[14] = '{3'd0, 32'h00000000, 32'h00001234, 32'h00000000};
        tbl[15] = '{3'd6, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9};
        tbl[16] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[17] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};

        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        a      = 32'h0;
        b      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("idle_no_done", 3);

        for (int i = 0; i < 18; i++) begin
            run_op(tbl[i].f, tbl[i].av, tbl[i].bv, res, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(tbl[i].f, tbl[i].av, tbl[i].bv));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
        end

        for (int i = 0; i < 150; i++) begin
            ef = 3'($urandom);
            ea = pick_operand();
            eb = pick_operand();
            run_op(ef, ea, eb, res, lat);
            chk($sformatf("rand%0d_f%0d_%h_%h", i, ef, ea, eb), res, ref_model(ef, ea, eb));
            chk($sformatf("rand%0d_latency", i), lat, exp_lat(ef, ea, eb));
        end
        chk("busy_done_overlap", overlap, 0);

        // Starts during CALC with new operands must be ignored.
        launch(3'd5, 32'd100, 32'd7);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            if (lat < 8) begin
                start  = 1'b1;
                a      = $urandom;
                b      = $urandom;
                funct3 = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("ignore_start_result", result, 32'd14);
        chk("ignore_start_latency", lat, 33);
        @(posedge clk);
        #1;
        chk("ignore_start_back_idle", 32'(done), 0);

        // Back-to-back: second start lands in the DONE cycle.
        run_op(3'd3, 32'hFFFFFFFF, 32'h2, res, lat);
        chk("b2b_first", res, 32'h1);
        launch(3'd4, 32'hFFFFFFF9, 32'h2);
        chk("b2b_done_drop", 32'(done), 0);
        chk("b2b_busy_rise", 32'(busy), 1);
        wait_done(lat);
        chk("b2b_second", result, 32'hFFFFFFFD);
        chk("b2b_latency", lat, 33);

        // Flush at count 15 keeps the previous result.
        run_op(3'd5, 32'd100, 32'd7, res, lat);
        chk("pre_flush", res, 32'd14);
        launch(3'd7, 32'd100, 32'd3);
        repeat (15) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_done", 32'(done), 0);
        chk("flush_result", result, 32'd14);
        watch_no_done("flush_no_done", 40);

        @(negedge clk);
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'd0;
        a      = 32'd3;
        b      = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 0);
        chk("flush_start_done", 32'(done), 0);
        watch_no_done("flush_start_no_done", 40);
        chk("flush_start_result", result, 32'd14);

        // Asynchronous reset in the middle of CALC.
        run_op(3'd3, 32'hFFFFFFFF, 32'h2, res, lat);
        chk("pre_reset", res, 32'h1);
        launch(3'd0, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_done", 32'(done), 0);
        chk("midreset_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("midreset_no_done", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
